// File: rtl/game_pkg.sv
// Shared game definitions: top-level game state and the saturating score step.
package game_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        OVER = 1'b1
    } game_state_t;

    // One point up (clamped at smax) or one point down (clamped at zero).
    function automatic logic [7:0] sat_score(input logic [7:0] cur,
                                             input logic       up,
                                             input logic [7:0] smax);
        logic [7:0] res;
        if (up) begin
            if (cur >= smax) begin
                res = smax;
            end else begin
                res = cur + 8'd1;
            end
        end else begin
            if (cur == 8'd0) begin
                res = 8'd0;
            end else begin
                res = cur - 8'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_cell.sv
// One player's channel: score and answered flag, updated by keys and slot boundaries.
module score_cell
    import game_pkg::*;
#(
    parameter int SCORE_MAX       = 9,
    parameter int TIMEOUT_PENALTY = 1,
    parameter int SCORE_W         = $clog2(SCORE_MAX + 1)
) (
    input  logic               clk_fast,
    input  logic               restart,
    input  logic               enable,
    input  logic               slot_edge,
    input  logic               key_valid,
    input  logic               answer,
    output logic [SCORE_W-1:0] score,
    output logic               answered
);

    logic [SCORE_W-1:0] score_d, score_q;
    logic               answered_d, answered_q;

    // Next-state rules for this player's score and answered flag.
    always_comb begin
        score_d    = score_q;
        answered_d = answered_q;
        if (enable) begin
            if (key_valid && !answered_q) begin
                score_d    = SCORE_W'(sat_score(8'(score_q), answer, 8'(SCORE_MAX)));
                answered_d = 1'b1;
            end else begin
                answered_d = answered_q;
            end
            // A key landing on the boundary counts for the ending slot and spares the penalty.
            if (slot_edge) begin
                if (!key_valid && !answered_q && (TIMEOUT_PENALTY != 0)) begin
                    score_d = SCORE_W'(sat_score(8'(score_q), 1'b0, 8'(SCORE_MAX)));
                end else begin
                    score_d = score_d;
                end
                answered_d = 1'b0;
            end else begin
                answered_d = answered_d;
            end
        end else begin
            score_d    = score_q;
            answered_d = answered_q;
        end
    end

    // Player state registers with synchronous restart.
    always_ff @(posedge clk_fast) begin
        if (restart) begin
            score_q    <= '0;
            answered_q <= 1'b0;
        end else begin
            score_q    <= score_d;
            answered_q <= answered_d;
        end
    end

    assign score    = score_q;
    assign answered = answered_q;

endmodule

// File: rtl/score_keeper.sv
// Quiz score keeper: slot-edge detection, RUN/OVER control, winner selection
// and packing of the per-player score cells.
module score_keeper
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int SCORE_MAX       = 9,
    parameter int TIMEOUT_PENALTY = 1
) (
    input  logic                                                clk_fast,
    input  logic                                                restart,
    input  logic                                                clk_slow,
    input  logic [NUM_PLAYERS-1:0]                              key_valid,
    input  logic [NUM_PLAYERS-1:0]                              answer,
    output logic [NUM_PLAYERS*$clog2(SCORE_MAX+1)-1:0]          score,
    output logic [NUM_PLAYERS-1:0]                              answered,
    output logic                                                game_over,
    output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] winner
);

    localparam int SCORE_W = $clog2(SCORE_MAX + 1);
    localparam int WIN_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic              slow_d, slow_q;
    game_state_t       state_d, state_q;
    logic [WIN_W-1:0]  winner_d, winner_q;
    logic              game_over_d, game_over_q;
    logic              slot_edge_s;
    logic              enable_s;
    logic              any_max_s;
    logic [WIN_W-1:0]  win_idx_s;
    logic [SCORE_W-1:0] cell_score_s [NUM_PLAYERS];

    assign slot_edge_s = clk_slow & ~slow_q;
    assign enable_s    = (state_q == RUN);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_cell
        score_cell #(
            .SCORE_MAX      (SCORE_MAX),
            .TIMEOUT_PENALTY(TIMEOUT_PENALTY),
            .SCORE_W        (SCORE_W)
        ) u_cell (
            .clk_fast (clk_fast),
            .restart  (restart),
            .enable   (enable_s),
            .slot_edge(slot_edge_s),
            .key_valid(key_valid[g]),
            .answer   (answer[g]),
            .score    (cell_score_s[g]),
            .answered (answered[g])
        );
        assign score[g*SCORE_W +: SCORE_W] = cell_score_s[g];
    end

    // Lowest-index player sitting at the winning score.
    always_comb begin
        any_max_s = 1'b0;
        win_idx_s = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (cell_score_s[i] == SCORE_W'(SCORE_MAX)) begin
                any_max_s = 1'b1;
                win_idx_s = WIN_W'(i);
            end else begin
                any_max_s = any_max_s;
            end
        end
    end

    // Game state, winner latch and slot-level tracking.
    always_comb begin
        slow_d   = clk_slow;
        state_d  = state_q;
        winner_d = winner_q;
        case (state_q)
            RUN: begin
                if (any_max_s) begin
                    state_d  = OVER;
                    winner_d = win_idx_s;
                end else begin
                    state_d  = RUN;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        game_over_d = (state_d == OVER);
    end

    // Top-level registers; slow_q restarts high so a held-high clk_slow is not an edge.
    always_ff @(posedge clk_fast) begin
        if (restart) begin
            slow_q      <= 1'b1;
            state_q     <= RUN;
            winner_q    <= '0;
            game_over_q <= 1'b0;
        end else begin
            slow_q      <= slow_d;
            state_q     <= state_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
        end
    end

    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
